seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_scan_driver.sv | 91 +++++++++
 tb/tb_seg7_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Digit-code and display-drive bundle between the SEG7 bus peripheral and the scan driver.
// The master supplies the codes and dots; the slave (the scan driver) drives anodes and segments.
interface seg7_scan_driver_if;
  logic [3:0] IN0;
  logic [3:0] IN1;
  logic [3:0] IN2;
  logic [3:0] IN3;
  logic [3:0] DOT_IN;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;

  modport master (
    output IN0, IN1, IN2, IN3, DOT_IN,
    input  SEG_SELECT_OUT, HEX_OUT
  );

  modport slave (
    input  IN0, IN1, IN2, IN3, DOT_IN,
    output SEG_SELECT_OUT, HEX_OUT
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with a blank gap at each digit switch.
// Digit codes are latched once per frame so a displayed frame never mixes old and new values.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               CLK,
  input  logic               RESET,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Team glyph set: blank, I, L, r, then hex 4..F. Result is active-high {G,F,E,D,C,B,A}.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'h00;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h38;
      4'h3:    s = 7'h50;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       sh_code [4];
  logic [3:0]       sh_dot;

  logic slot_end;
  logic visible;

  assign slot_end = (cnt == CNT_LAST);
  assign visible  = (int'(cnt) >= BLANK_CYCLES);

  // Stage 0: slot counter, digit index and frame-boundary shadow load
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh_dot     <= 4'h0;
      sh_code[0] <= 4'h0;
      sh_code[1] <= 4'h0;
      sh_code[2] <= 4'h0;
      sh_code[3] <= 4'h0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sh_code[0] <= bus.IN0;
          sh_code[1] <= bus.IN1;
          sh_code[2] <= bus.IN2;
          sh_code[3] <= bus.IN3;
          sh_dot     <= bus.DOT_IN;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: registered anode and segment drive, all off during the blank gap
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.SEG_SELECT_OUT <= 4'hF;
      bus.HEX_OUT        <= 8'hFF;
    end else if (visible) begin
      bus.SEG_SELECT_OUT <= ~(4'b0001 << idx);
      bus.HEX_OUT        <= {~sh_dot[idx], ~seg_decode(sh_code[idx])};
    end else begin
      bus.SEG_SELECT_OUT <= 4'hF;
      bus.HEX_OUT        <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_driver;
  localparam int RD = 8;
  localparam int BC = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sweep_tab [16] = '{8'hFF, 8'hF9, 8'hC7, 8'hAF, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic skip(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One cycle of a slot: position i within the slot, digit d, expected segments h when lit
  task automatic cyc_chk(input string tag, input int i, input int d, input logic [7:0] h);
    logic [3:0] sel;
    tick();
    case (d)
      0:       sel = 4'hE;
      1:       sel = 4'hD;
      2:       sel = 4'hB;
      default: sel = 4'h7;
    endcase
    if (i < BC) begin
      chk($sformatf("%s sel gap c%0d", tag, i), {4'h0, bus.SEG_SELECT_OUT}, 8'h0F);
      chk($sformatf("%s hex gap c%0d", tag, i), bus.HEX_OUT, 8'hFF);
    end else begin
      chk($sformatf("%s sel c%0d", tag, i), {4'h0, bus.SEG_SELECT_OUT}, {4'h0, sel});
      chk($sformatf("%s hex c%0d", tag, i), bus.HEX_OUT, h);
    end
  endtask

  task automatic check_slot(input string tag, input int d, input logic [7:0] h);
    for (int i = 0; i < RD; i++) cyc_chk(tag, i, d, h);
  endtask

  initial begin
    bus.IN0 = 4'h2;
    bus.IN1 = 4'hF;
    bus.IN2 = 4'h0;
    bus.IN3 = 4'h0;
    bus.DOT_IN = 4'h0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst sel", {4'h0, bus.SEG_SELECT_OUT}, 8'h0F);
      chk("rst hex", bus.HEX_OUT, 8'hFF);
    end
    RESET = 1'b0;

    // Frame 0: blank shadow
    for (int d = 0; d < 4; d++) check_slot($sformatf("f0 d%0d", d), d, 8'hFF);

    // Frame 1: L on digit 0, F on digit 1; IN0 changes mid digit-1 slot
    check_slot("f1 d0", 0, 8'hC7);
    for (int i = 0; i < RD; i++) begin
      if (i == 4) bus.IN0 = 4'h3;
      cyc_chk("f1 d1", i, 1, 8'h8E);
    end
    check_slot("f1 d2", 2, 8'hFF);
    check_slot("f1 d3", 3, 8'hFF);

    // Frame 2: r on digit 0; dot and IN1 change right before the load edge
    check_slot("f2 d0", 0, 8'hAF);
    check_slot("f2 d1", 1, 8'h8E);
    check_slot("f2 d2", 2, 8'hFF);
    for (int i = 0; i < RD; i++) begin
      if (i == RD - 1) begin
        bus.IN1 = 4'hB;
        bus.DOT_IN = 4'b0010;
      end
      cyc_chk("f2 d3", i, 3, 8'hFF);
    end

    // Frame 3: decimal point on digit 1 only
    check_slot("f3 d0", 0, 8'hAF);
    check_slot("f3 d1", 1, 8'h03);
    bus.DOT_IN = 4'h0;
    bus.IN0 = 4'h0;
    check_slot("f3 d2", 2, 8'hFF);
    check_slot("f3 d3", 3, 8'hFF);

    // Frames 4..19: decode sweep on digit 0
    for (int c = 0; c < 16; c++) begin
      check_slot($sformatf("sweep %0h", c), 0, sweep_tab[c]);
      if (c < 15) bus.IN0 = 4'(c + 1);
      skip(3 * RD);
    end

    // Frame 20: reset while digit 2 is lit
    check_slot("f20 d0", 0, 8'h8E);
    check_slot("f20 d1", 1, 8'h83);
    for (int i = 0; i < 5; i++) cyc_chk("f20 d2", i, 2, 8'hFF);
    RESET = 1'b1;
    tick();
    chk("midrst sel", {4'h0, bus.SEG_SELECT_OUT}, 8'h0F);
    chk("midrst hex", bus.HEX_OUT, 8'hFF);
    RESET = 1'b0;

    // Scan restarts at digit 0 with a blank shadow
    check_slot("post d0", 0, 8'hFF);
    check_slot("post d1", 1, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
